// File: rtl/serial_subtractor_pkg.sv
// Shared ALU definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_subtractor_pkg;

    // Default operand width for ALU sub-blocks.
    localparam int DEFAULT_WIDTH = 8;

    // Control states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width for a given operand width (CNT_W = $clog2(WIDTH)).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus between the ALU control
// sequencer (master) and the serial subtractor (slave).
// Optional: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    // Sequencer side: issues operands, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_subtractor_full_adder.sv
// The ALU's 1-bit full-adder cell; purely combinational.
module serial_subtractor_full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, computed as a + ~b + 1 through a single full-adder cell.
// Optional: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;       // minuend shifter, doubles as result register
    logic [WIDTH-1:0] b_q;       // inverted subtrahend shifter
    logic [WIDTH-1:0] diff_q;
    logic             carry_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sum;
    logic             carry_out;
    logic             accept;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
    assign bus.ovf = ovf_q;
`endif

    // Starts are only honoured in IDLE; RUN and DONE ignore them.
    assign accept   = (state_q == IDLE) && bus.start;
    assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    serial_subtractor_full_adder u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (carry_q),
        .s    (sum),
        .cout (carry_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        bus.busy = (state_q == RUN) || (state_q == DONE);
        bus.done = (state_q == DONE);
    end

    // Datapath: capture on accept, shift one bit per RUN edge, publish on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are plain flops, so all of them reset; a reset mid-operation
        // leaves nothing stale that could leak into diff/borrow.
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= ~bus.b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            // Vacated MSBs of the minuend shifter collect the sum bits, so after
            // WIDTH shifts it holds the result.
            a_q     <= {sum, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            carry_q <= carry_out;
            cnt_q   <= cnt_q + 1'b1;
            if (last_bit) begin
                diff_q   <= {sum, a_q[WIDTH-1:1]};
                borrow_q <= ~carry_out;
`ifdef SERIAL_SUB_OVF_EN
                ovf_q    <= (a_msb_q != b_msb_q) && (sum != a_msb_q);
`endif
            end
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases,
// ignored-start and reset-abort scenarios, then a random back-to-back sweep
// checked against an arithmetic reference model.
// Optional: build with SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_subtractor;

    localparam int W        = 8;
    localparam int MAX_WAIT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required summary before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: modular difference and unsigned borrow.
    function automatic logic [W-1:0] exp_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(int'(a) - int'(b));
    endfunction

    function automatic logic exp_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return int'(a) < int'(b);
    endfunction

`ifdef SERIAL_SUB_OVF_EN
    // Reference: signed result outside the W-bit two's-complement range.
    function automatic logic exp_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, r;
        sa = (int'(a) >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
        sb = (int'(b) >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
        r  = sa - sb;
        return (r >= 2**(W-1)) || (r < -(2**(W-1)));
    endfunction
`endif

    // Issue one operation from IDLE and check latency, busy, result and the
    // single-cycle done pulse. Returns the cycle number of the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int done_cyc);
        int n;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        n = 1;
        while (!bus.done && n < MAX_WAIT) begin
            check("busy_in_run", bus.busy, 1);
            tick();
            n++;
        end
        check("done_latency", n, W + 1);
        check("busy_in_done", bus.busy, 1);
        check("diff", bus.diff, exp_diff(a, b));
        check("borrow", bus.borrow, exp_borrow(a, b));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", bus.ovf, exp_ovf(a, b));
`endif
        done_cyc = cyc;
        tick();
        check("done_one_cycle", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
        check("diff_hold", bus.diff, exp_diff(a, b));
    endtask

    initial begin
        int dc;
        int prev;
        int dones;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);

        // Directed cases
        run_op(8'h05, 8'h03, dc);
        check("dir_05_03", bus.diff, 8'h02);
        run_op(8'h03, 8'h05, dc);
        check("dir_03_05", bus.diff, 8'hFE);
        check("dir_03_05_borrow", bus.borrow, 1);
        run_op(8'h80, 8'h01, dc);
        check("dir_80_01", bus.diff, 8'h7F);
        run_op(8'h00, 8'h00, dc);
        check("dir_00_00", bus.diff, 8'h00);

        // Starts during RUN cycle 3 and during DONE are ignored
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        tick();
        dones = 0;
        for (int i = 1; i <= W; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) dones++;
            tick();
        end
        check("ign_no_early_done", dones, 0);
        check("ign_done", bus.done, 1);
        check("ign_diff", bus.diff, 8'h0F);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        tick();
        bus.start = 1'b0;
        check("ign_done_start_busy", bus.busy, 0);
        check("ign_done_start_done", bus.done, 0);
        check("ign_diff_hold", bus.diff, 8'h0F);
        run_op(8'h33, 8'h11, dc);

        // Reset during RUN cycle 4 aborts immediately
        bus.start = 1'b1;
        bus.a     = 8'h40;
        bus.b     = 8'h05;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("pre_abort_busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_diff", bus.diff, 0);
        check("abort_borrow", bus.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", bus.ovf, 0);
`endif
        tick();
        tick();
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        check("abort_stays_idle", dones, 0);
        run_op(8'h20, 8'h10, dc);
        check("post_abort_diff", bus.diff, 8'h10);

        // Random back-to-back sweep
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            run_op(W'($urandom), W'($urandom), dc);
            if (i > 0) check("done_spacing", dc - prev, W + 2);
            prev = dc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
